// File: rtl/planta_maquina_lavar.sv
// Behavioural washer plant: tank level, agitation and spin timers, conflict flag.
// Optional leak model in idle enabled by defining PLANTA_VAZAMENTO_EN.
module planta_maquina_lavar #(
    parameter int NIVEL_MAX    = 15,
    parameter int TAXA_ENCHER  = 1,
    parameter int TAXA_DRENO   = 2,
    parameter int TEMPO_AGITAR = 20,
    parameter int TEMPO_GIRAR  = 10,
`ifdef PLANTA_VAZAMENTO_EN
    parameter int PERIODO_VAZAMENTO = 8,
`endif
    parameter int NIVEL_W = $clog2(NIVEL_MAX + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valvula_agua,
    input  logic               modo_agitar,
    input  logic               modo_girar,
    output logic               cheio,
    output logic               tempo,
    output logic               secar,
    output logic [NIVEL_W-1:0] nivel,
    output logic               erro
);

    typedef enum logic [2:0] {
        PARADO,
        ENCHENDO,
        AGITANDO,
        CENTRIFUGANDO,
        CONFLITO
    } fase_t;

    localparam int TMAX = (TEMPO_AGITAR > TEMPO_GIRAR) ? TEMPO_AGITAR : TEMPO_GIRAR;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [NIVEL_W-1:0] NMAX = NIVEL_W'(NIVEL_MAX);
    localparam logic [NIVEL_W-1:0] TE   = NIVEL_W'(TAXA_ENCHER);
    localparam logic [NIVEL_W-1:0] TD   = NIVEL_W'(TAXA_DRENO);
    localparam logic [TW-1:0]      TA   = TW'(TEMPO_AGITAR);
    localparam logic [TW-1:0]      TG   = TW'(TEMPO_GIRAR);

    fase_t              fase_q, fase_d;
    logic [NIVEL_W-1:0] nivel_q, nivel_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               tempo_q, tempo_d;
    logic               secar_q, secar_d;
    logic               erro_q, erro_d;
    logic [NIVEL_W:0]   soma;
    logic               mesma_fase;

`ifdef PLANTA_VAZAMENTO_EN
    localparam int VW = $clog2(PERIODO_VAZAMENTO + 1);
    localparam logic [VW-1:0] VFIM = VW'(PERIODO_VAZAMENTO - 1);
    logic [VW-1:0] vaz_q, vaz_d;
`endif

    always_comb begin
        case ({valvula_agua, modo_agitar, modo_girar})
            3'b000:  fase_d = PARADO;
            3'b100:  fase_d = ENCHENDO;
            3'b010:  fase_d = AGITANDO;
            3'b001:  fase_d = CENTRIFUGANDO;
            default: fase_d = CONFLITO;
        endcase
    end

    assign mesma_fase = (fase_d == fase_q);
    // One bit wider so the fill step can never wrap past full.
    assign soma = {1'b0, nivel_q} + {1'b0, TE};

    always_comb begin
        nivel_d = nivel_q;
        timer_d = mesma_fase ? timer_q : '0;
        tempo_d = 1'b0;
        secar_d = 1'b0;
        erro_d  = erro_q;
        case (fase_d)
            ENCHENDO: begin
                nivel_d = (soma > {1'b0, NMAX}) ? NMAX : soma[NIVEL_W-1:0];
            end
            AGITANDO: begin
                if (mesma_fase && timer_q < TA)
                    timer_d = timer_q + 1'b1;
                tempo_d = (timer_d == TA);
            end
            CENTRIFUGANDO: begin
                nivel_d = (nivel_q > TD) ? nivel_q - TD : '0;
                if (mesma_fase && timer_q < TG)
                    timer_d = timer_q + 1'b1;
                secar_d = (nivel_d != '0) || (timer_d < TG);
            end
            CONFLITO: begin
                timer_d = timer_q;
                secar_d = secar_q;
                erro_d  = 1'b1;
            end
            default: ;
        endcase
`ifdef PLANTA_VAZAMENTO_EN
        vaz_d = '0;
        if (fase_d == PARADO) begin
            vaz_d = (vaz_q == VFIM) ? '0 : vaz_q + 1'b1;
            if (vaz_q == VFIM && nivel_q != '0)
                nivel_d = nivel_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fase_q  <= PARADO;
            nivel_q <= '0;
            timer_q <= '0;
            tempo_q <= 1'b0;
            secar_q <= 1'b0;
            erro_q  <= 1'b0;
`ifdef PLANTA_VAZAMENTO_EN
            vaz_q   <= '0;
`endif
        end else begin
            fase_q  <= fase_d;
            nivel_q <= nivel_d;
            timer_q <= timer_d;
            tempo_q <= tempo_d;
            secar_q <= secar_d;
            erro_q  <= erro_d;
`ifdef PLANTA_VAZAMENTO_EN
            vaz_q   <= vaz_d;
`endif
        end
    end

    assign cheio = (nivel_q == NMAX);
    assign tempo = tempo_q;
    assign secar = secar_q;
    assign nivel = nivel_q;
    assign erro  = erro_q;

endmodule

// File: tb/tb_planta_maquina_lavar.sv
// Directed checks of the washer plant model against hand-derived values.
module tb_planta_maquina_lavar;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valvula_agua = 1'b0;
    logic       modo_agitar = 1'b0;
    logic       modo_girar = 1'b0;
    logic       cheio, tempo, secar, erro;
    logic [3:0] nivel;

    int passed = 0;
    int total  = 0;

    planta_maquina_lavar dut (
        .clock        (clock),
        .reset        (reset),
        .valvula_agua (valvula_agua),
        .modo_agitar  (modo_agitar),
        .modo_girar   (modo_girar),
        .cheio        (cheio),
        .tempo        (tempo),
        .secar        (secar),
        .nivel        (nivel),
        .erro         (erro)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_nivel"}, int'(nivel), 0);
        check({tag, "_cheio"}, int'(cheio), 0);
        check({tag, "_tempo"}, int'(tempo), 0);
        check({tag, "_secar"}, int'(secar), 0);
        check({tag, "_erro"},  int'(erro),  0);
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        cyc(1);
        check_zero("rst");
        reset = 1'b0;

        // fill 1..15, cheio only at full, then hold at full
        valvula_agua = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            check("fill_nivel", int'(nivel), i);
            check("fill_cheio", int'(cheio), (i == 15) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("full_nivel", int'(nivel), 15);
            check("full_cheio", int'(cheio), 1);
        end

        // agitate: 20 cycles low, then high and held
        valvula_agua = 1'b0;
        modo_agitar  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            check("agit_tempo_lo", int'(tempo), 0);
            check("agit_nivel", int'(nivel), 15);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("agit_tempo_hi", int'(tempo), 1);
        end
        modo_agitar = 1'b0;
        cyc(1);
        check("agit_drop_tempo", int'(tempo), 0);

        // spin: drain 2/cycle, secar until timer hits 10
        modo_girar = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            check("spin_nivel", int'(nivel), (15 - 2 * i > 0) ? 15 - 2 * i : 0);
            check("spin_secar", int'(secar), (i <= 10) ? 1 : 0);
        end
        modo_girar = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            check("spin_drop_secar", int'(secar), 0);
        end

        // conflict at nivel=5
        valvula_agua = 1'b1;
        cyc(5);
        check("pre_conf_nivel", int'(nivel), 5);
        modo_girar = 1'b1;
        cyc(1);
        check("conf_erro", int'(erro), 1);
        check("conf_nivel", int'(nivel), 5);
        valvula_agua = 1'b0;
        modo_girar   = 1'b0;
        cyc(3);
        check("conf_sticky_erro", int'(erro), 1);
        check("conf_sticky_nivel", int'(nivel), 5);

        reset = 1'b1;
        cyc(1);
        check_zero("rst2");
        reset = 1'b0;

        // reset mid-fill at nivel=7
        valvula_agua = 1'b1;
        cyc(7);
        check("midfill_nivel", int'(nivel), 7);
        reset = 1'b1;
        cyc(1);
        check_zero("rst_mid");
        reset = 1'b0;

        // idle leak (or hold when the leak model is absent)
        cyc(16);
        check("pre_idle_nivel", int'(nivel), 15);
        valvula_agua = 1'b0;
        cyc(8);
`ifdef PLANTA_VAZAMENTO_EN
        check("idle8_nivel", int'(nivel), 14);
`else
        check("idle8_nivel", int'(nivel), 15);
`endif
        cyc(8);
`ifdef PLANTA_VAZAMENTO_EN
        check("idle16_nivel", int'(nivel), 13);
`else
        check("idle16_nivel", int'(nivel), 15);
`endif
        check("idle_erro", int'(erro), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
